// File: rtl/quant_uv_block.sv
// Chroma 4x4 quantizer: 8 blocks through a 2-stage pipeline, one block per cycle.
// Emits zigzag levels, raster dequantized coefficients and a per-block non-zero mask.
module quant_uv_block #(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [BIT_WIDTH*16*BLOCK_SIZE-1:0] coeffs_in,
    input  logic [15:0]                        q_dc,
    input  logic [15:0]                        q_ac,
    input  logic [16:0]                        iq_dc,
    input  logic [16:0]                        iq_ac,
    input  logic [31:0]                        bias_dc,
    input  logic [31:0]                        bias_ac,
    input  logic [31:0]                        zthresh_dc,
    input  logic [31:0]                        zthresh_ac,
    output logic [BIT_WIDTH*16*BLOCK_SIZE-1:0] levels,
    output logic [BIT_WIDTH*16*BLOCK_SIZE-1:0] coeffs_out,
    output logic [BLOCK_SIZE-1:0]              nz,
    output logic                               busy,
    output logic                               done
);
    localparam int BW    = BIT_WIDTH;
    localparam int BLK_W = 16 * BW;
    localparam int W     = BLK_W * BLOCK_SIZE;
    localparam int CW    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    // zigzag position n -> raster index, one nibble per n
    localparam logic [63:0] ZZ = 64'hFEB7ADC963258410;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, blk_q, blk_d;
    logic            issue_q, issue_d, s1v_q, s1v_d;
    logic            last_q, last_d, busy_q, busy_d, done_q, done_d;

    logic [BW-1:0]   c_d   [16];
    logic [BW:0]     a_d   [16];
    logic [34:0]     sum_d [16];
    logic [34:0]     sum_q [16];
    logic [15:0]     gt_d, gt_q, sgn_d, sgn_q;

    logic [34:0]     sh    [16];
    logic [10:0]     mag   [16];
    logic [BW-1:0]   lv    [16];
    logic [BW-1:0]   deq   [16];
    logic [BW-1:0]   qx    [16];
    logic            any_nz;

    logic [W-1:0]          levels_q, coeffs_q;
    logic [BLOCK_SIZE-1:0] nz_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        issue_d = issue_q;
        s1v_d   = 1'b0;
        last_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    issue_d = 1'b1;
                end
            end
            RUN: begin
                if (issue_q) begin
                    s1v_d = 1'b1;
                    blk_d = cnt_q;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BLOCK_SIZE - 1))
                        issue_d = 1'b0;
                end
                if (s1v_q && blk_q == CW'(BLOCK_SIZE - 1))
                    last_d = 1'b1;
                if (last_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: gather the block in zigzag order, take magnitude and product.
    always_comb begin
        gt_d  = '0;
        sgn_d = '0;
        for (int n = 0; n < 16; n++) begin
            c_d[n] = coeffs_in[int'(cnt_q)*BLK_W + BW*int'(ZZ[4*n +: 4]) +: BW];
            sgn_d[n] = c_d[n][BW-1];
            a_d[n] = sgn_d[n] ? ((BW+1)'(0) - {1'b1, c_d[n]}) : {1'b0, c_d[n]};
            gt_d[n] = 32'(a_d[n]) > ((n == 0) ? zthresh_dc : zthresh_ac);
            sum_d[n] = 35'(a_d[n]) * 35'((n == 0) ? iq_dc : iq_ac)
                     + 35'((n == 0) ? bias_dc : bias_ac);
        end
    end

    // Stage 2: shift, clamp, restore sign, dequantize.
    always_comb begin
        any_nz = 1'b0;
        for (int n = 0; n < 16; n++) begin
            sh[n]  = sum_q[n] >> 17;
            mag[n] = !gt_q[n] ? 11'd0
                   : (sh[n] > 35'd2047) ? 11'd2047 : sh[n][10:0];
            lv[n]  = sgn_q[n] ? (BW'(0) - BW'(mag[n])) : BW'(mag[n]);
            qx[n]  = BW'((n == 0) ? q_dc : q_ac);
            deq[n] = lv[n] * qx[n];
            any_nz = any_nz | (|lv[n]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            issue_q <= 1'b0;
            s1v_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            issue_q <= issue_d;
            s1v_q   <= s1v_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 16; n++)
                sum_q[n] <= '0;
            gt_q  <= '0;
            sgn_q <= '0;
        end else if (issue_q) begin
            for (int n = 0; n < 16; n++)
                sum_q[n] <= sum_d[n];
            gt_q  <= gt_d;
            sgn_q <= sgn_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            levels_q <= '0;
            coeffs_q <= '0;
            nz_q     <= '0;
        end else if (s1v_q) begin
            for (int n = 0; n < 16; n++) begin
                levels_q[int'(blk_q)*BLK_W + BW*n +: BW] <= lv[n];
                coeffs_q[int'(blk_q)*BLK_W + BW*int'(ZZ[4*n +: 4]) +: BW] <= deq[n];
            end
            nz_q[blk_q] <= any_nz;
        end
    end

    assign levels     = levels_q;
    assign coeffs_out = coeffs_q;
    assign nz         = nz_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_quant_uv_block.sv
// Bench for quant_uv_block: directed and random runs scored against an arithmetic model.
module tb_quant_uv_block;
    localparam int BW = 16;
    localparam int BS = 8;
    localparam int W  = BW * 16 * BS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  coeffs_in = '0;
    logic [15:0]   q_dc = '0, q_ac = '0;
    logic [16:0]   iq_dc = '0, iq_ac = '0;
    logic [31:0]   bias_dc = '0, bias_ac = '0;
    logic [31:0]   zthresh_dc = '0, zthresh_ac = '0;
    logic [W-1:0]  levels, coeffs_out;
    logic [BS-1:0] nz;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_lv, exp_co;
    logic [BS-1:0] exp_nz;
    int zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    quant_uv_block #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .coeffs_in(coeffs_in),
        .q_dc(q_dc), .q_ac(q_ac), .iq_dc(iq_dc), .iq_ac(iq_ac),
        .bias_dc(bias_dc), .bias_ac(bias_ac),
        .zthresh_dc(zthresh_dc), .zthresh_ac(zthresh_ac),
        .levels(levels), .coeffs_out(coeffs_out), .nz(nz),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: quantize every coefficient straight from the rules.
    task automatic model();
        logic signed [15:0] c;
        longint a, l, lv, iq, bias, zt, q;
        exp_lv = '0;
        exp_co = '0;
        exp_nz = '0;
        for (int b = 0; b < BS; b++) begin
            for (int n = 0; n < 16; n++) begin
                int j;
                j = zz[n];
                c = coeffs_in[b*256 + 16*j +: 16];
                a = (c < 0) ? -longint'(c) : longint'(c);
                iq   = (j == 0) ? longint'(iq_dc) : longint'(iq_ac);
                bias = (j == 0) ? longint'(bias_dc) : longint'(bias_ac);
                zt   = (j == 0) ? longint'(zthresh_dc) : longint'(zthresh_ac);
                q    = (j == 0) ? longint'(q_dc) : longint'(q_ac);
                l = 0;
                if (a > zt) begin
                    l = (a * iq + bias) / 131072;
                    if (l > 2047) l = 2047;
                end
                lv = (c < 0) ? -l : l;
                exp_lv[b*256 + 16*n +: 16] = 16'(lv);
                exp_co[b*256 + 16*j +: 16] = 16'(lv * q);
                if (lv != 0) exp_nz[b] = 1'b1;
            end
        end
    endtask

    function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 0; i < 16*BS; i++)
            if (x[16*i +: 16] !== y[16*i +: 16]) return i;
        return 0;
    endfunction

    task automatic set_coef(input int b, input int j, input int v);
        coeffs_in[b*256 + 16*j +: 16] = 16'(v);
    endtask

    task automatic set_defaults();
        q_dc = 16'd10; iq_dc = 17'd13107; bias_dc = 32'd56320; zthresh_dc = 32'd5;
        q_ac = 16'd10; iq_ac = 17'd13107; bias_ac = 32'd56320; zthresh_ac = 32'd5;
    endtask

    task automatic rand_coeffs();
        for (int i = 0; i < 16*BS; i++) begin
            int r;
            r = int'($urandom_range(0, 3));
            case (r)
                0: coeffs_in[16*i +: 16] = 16'd0;
                1: coeffs_in[16*i +: 16] = 16'(int'($urandom_range(0, 60)) - 30);
                2: coeffs_in[16*i +: 16] = 16'(int'($urandom_range(0, 4000)) - 2000);
                default: coeffs_in[16*i +: 16] = 16'($urandom);
            endcase
        end
    endtask

    task automatic rand_params();
        q_dc = 16'($urandom_range(2, 127));
        q_ac = 16'($urandom_range(2, 127));
        iq_dc = 17'(131072 / int'(q_dc));
        iq_ac = 17'(131072 / int'(q_ac));
        bias_dc = $urandom_range(0, 131072);
        bias_ac = $urandom_range(0, 131072);
        zthresh_dc = $urandom_range(0, 20);
        zthresh_ac = $urandom_range(0, 20);
    endtask

    // Pulse start; returns 1 time unit after the sampling edge.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (levels !== '0 || coeffs_out !== '0) begin
            errors++;
            $display("FAIL reset_data levels/coeffs not zero");
        end
        checks++;
        if (nz !== '0) begin
            errors++;
            $display("FAIL reset_nz got %h exp 00", nz);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl busy %b done %b exp 0 0", busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        int lat, k;
        set_defaults();
        coeffs_in = '0;
        set_coef(0, 1, 25);
        set_coef(0, 4, -25);
        model();
        kick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL dflt_busy got %b exp 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL dflt_latency got %0d exp 10", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL dflt_busy_at_done got %b exp 0", busy);
        end
        checks++;
        if (levels[31:16] !== 16'd2 || levels[47:32] !== 16'hFFFE) begin
            errors++;
            $display("FAIL dflt_lv got %h %h exp 0002 fffe", levels[31:16], levels[47:32]);
        end
        checks++;
        if (coeffs_out[31:16] !== 16'd20 || coeffs_out[79:64] !== 16'hFFEC) begin
            errors++;
            $display("FAIL dflt_co got %h %h exp 0014 ffec",
                     coeffs_out[31:16], coeffs_out[79:64]);
        end
        checks++;
        if (nz !== 8'h01) begin
            errors++;
            $display("FAIL dflt_nz got %h exp 01", nz);
        end
        checks++;
        if (levels !== exp_lv || coeffs_out !== exp_co) begin
            errors++;
            k = first_diff(levels, exp_lv);
            $display("FAIL dflt_model lane %0d got %h exp %h", k,
                     levels[16*k +: 16], exp_lv[16*k +: 16]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL dflt_done_width got %b exp 0", done);
        end
    endtask

    task automatic test_threshold();
        int lat;
        set_defaults();
        coeffs_in = '0;
        set_coef(0, 1, 5);
        set_coef(0, 2, 6);
        model();
        kick();
        wait_done(lat);
        checks++;
        if (levels[31:16] !== 16'd0 || levels[95:80] !== 16'd1) begin
            errors++;
            $display("FAIL thr_lv got %h %h exp 0000 0001", levels[31:16], levels[95:80]);
        end
        checks++;
        if (coeffs_out[47:32] !== 16'd10 || coeffs_out !== exp_co) begin
            errors++;
            $display("FAIL thr_co got %h exp 000a", coeffs_out[47:32]);
        end
    endtask

    task automatic test_clamp();
        int lat;
        set_defaults();
        q_ac = 16'd2; iq_ac = 17'd65536; bias_ac = 32'd0; zthresh_ac = 32'd0;
        coeffs_in = '0;
        set_coef(0, 3, 32767);
        set_coef(0, 5, -32768);
        model();
        kick();
        wait_done(lat);
        checks++;
        if (levels[111:96] !== 16'd2047 || levels[79:64] !== 16'hF801) begin
            errors++;
            $display("FAIL clamp_lv got %h %h exp 07ff f801", levels[111:96], levels[79:64]);
        end
        checks++;
        if (coeffs_out[63:48] !== 16'd4094 || coeffs_out[95:80] !== 16'hF002) begin
            errors++;
            $display("FAIL clamp_co got %h %h exp 0ffe f002",
                     coeffs_out[63:48], coeffs_out[95:80]);
        end
        checks++;
        if (levels !== exp_lv || nz !== exp_nz) begin
            errors++;
            $display("FAIL clamp_model nz got %h exp %h", nz, exp_nz);
        end
    endtask

    task automatic test_dc_ac();
        int lat;
        longint cost_dut, cost_ref;
        logic signed [15:0] s;
        set_defaults();
        q_dc = 16'd4; iq_dc = 17'd32768;
        coeffs_in = '0;
        for (int b = 0; b < BS; b++) set_coef(b, 0, 100);
        model();
        kick();
        wait_done(lat);
        checks++;
        if (levels[15:0] !== 16'd25 || levels[7*256 +: 16] !== 16'd25) begin
            errors++;
            $display("FAIL dcac_lv got %h %h exp 0019 0019", levels[15:0], levels[7*256 +: 16]);
        end
        checks++;
        if (nz !== 8'hFF) begin
            errors++;
            $display("FAIL dcac_nz got %h exp ff", nz);
        end
        cost_dut = 0;
        cost_ref = 0;
        for (int i = 0; i < 16*BS; i++) begin
            s = levels[16*i +: 16];
            cost_dut += longint'(s) * longint'(s);
            s = exp_lv[16*i +: 16];
            cost_ref += longint'(s) * longint'(s);
        end
        checks++;
        if (cost_dut != cost_ref) begin
            errors++;
            $display("FAIL dcac_cost got %0d exp %0d", cost_dut, cost_ref);
        end
    endtask

    task automatic test_random();
        int lat, k;
        for (int r = 0; r < 6; r++) begin
            rand_params();
            rand_coeffs();
            model();
            kick();
            wait_done(lat);
            checks++;
            if (lat != 10) begin
                errors++;
                $display("FAIL rand_latency run %0d got %0d exp 10", r, lat);
            end
            checks++;
            if (levels !== exp_lv) begin
                errors++;
                k = first_diff(levels, exp_lv);
                $display("FAIL rand_levels run %0d lane %0d got %h exp %h", r, k,
                         levels[16*k +: 16], exp_lv[16*k +: 16]);
            end
            checks++;
            if (coeffs_out !== exp_co) begin
                errors++;
                k = first_diff(coeffs_out, exp_co);
                $display("FAIL rand_coeffs run %0d lane %0d got %h exp %h", r, k,
                         coeffs_out[16*k +: 16], exp_co[16*k +: 16]);
            end
            checks++;
            if (nz !== exp_nz) begin
                errors++;
                $display("FAIL rand_nz run %0d got %h exp %h", r, nz, exp_nz);
            end
        end
    endtask

    task automatic test_ignored_start();
        int first, count;
        rand_params();
        rand_coeffs();
        model();
        kick();
        first = -1;
        count = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) start = 1'b1;
            if (i == 3) start = 1'b0;
            if (done) begin
                count++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (count != 1 || first != 10) begin
            errors++;
            $display("FAIL ignore_start dones %0d first %0d exp 1 at 10", count, first);
        end
        checks++;
        if (levels !== exp_lv || coeffs_out !== exp_co) begin
            errors++;
            $display("FAIL ignore_start_data outputs differ from model");
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        rand_params();
        rand_coeffs();
        model();
        kick();
        wait_done(lat1);
        checks++;
        if (lat1 != 10 || levels !== exp_lv || nz !== exp_nz) begin
            errors++;
            $display("FAIL b2b_first lat %0d nz %h exp 10 %h", lat1, nz, exp_nz);
        end
        rand_coeffs();
        model();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat2);
        checks++;
        if (lat2 != 10) begin
            errors++;
            $display("FAIL b2b_latency got %0d exp 10", lat2);
        end
        checks++;
        if (levels !== exp_lv || coeffs_out !== exp_co || nz !== exp_nz) begin
            errors++;
            $display("FAIL b2b_second nz got %h exp %h", nz, exp_nz);
        end
    endtask

    task automatic test_zero();
        int lat;
        coeffs_in = '0;
        set_defaults();
        kick();
        wait_done(lat);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL zero_latency got %0d exp 10", lat);
        end
        checks++;
        if (levels !== '0 || coeffs_out !== '0 || nz !== '0) begin
            errors++;
            $display("FAIL zero_data nz got %h exp 00", nz);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] old_lv;
        int count;
        old_lv = levels;
        rand_params();
        rand_coeffs();
        model();
        kick();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (levels[0 +: 1024] !== exp_lv[0 +: 1024] ||
            levels[1024 +: 1024] !== old_lv[1024 +: 1024]) begin
            errors++;
            $display("FAIL partial_update blocks 0-3 new / 4-7 old not held");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (levels !== '0 || coeffs_out !== '0 || nz !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear busy %b done %b nz %h exp 0 0 00", busy, done, nz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        count = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) count++;
        end
        checks++;
        if (count != 0) begin
            errors++;
            $display("FAIL midreset_done got %0d pulses exp 0", count);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_threshold();
        test_clamp();
        test_dc_ac();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_zero();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
